cc_unit: RTL and testbench

//  Condition-code stage directly downstream of the 64-bit execute ALU.
//  - Latches ZF/SF/OF from the ALU result and overflow whenever an OPq instruction commits.
//  - Evaluates the Y86 condition function (jXX/cmovXX ifun) against the latched flags and drives cnd to fetch/writeback.

---
 rtl/cc_unit.sv | 140 ++++++++++++++
 tb/tb_cc_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cc_unit.sv
// Condition-code stage: latches ZF/SF/OF on committed OPq results and evaluates Y86 jXX/cmovXX conditions.
// Optional taken/not-taken statistics counters are enabled by defining CC_STATS_EN.
module cc_unit #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_cc,
  input  logic             cc_stall,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  input  logic             eval_valid,
  input  logic [3:0]       cond_fn,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             cond_err,
  output logic             cc_live
`ifdef CC_STATS_EN
  ,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] ntaken_cnt
`endif
);

  typedef enum logic {
    RST_CC = 1'b0,
    LIVE   = 1'b1
  } cc_state_e;

  cc_state_e state_q, state_d;
  logic      zf_q, zf_d;
  logic      sf_q, sf_d;
  logic      of_q, of_d;
  logic      commit;

  // Stall has priority over a capture request.
  assign commit = set_cc & ~cc_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_CC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_CC:  if (commit) state_d = LIVE;
      LIVE:    state_d = LIVE;
      default: state_d = RST_CC;
    endcase
  end

  always_comb begin
    cc_live = 1'b0;
    if (state_q == LIVE) cc_live = 1'b1;
  end

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (commit) begin
      zf_d = (alu_out == '0);
      sf_d = alu_out[WIDTH-1];
      of_d = alu_ovf;
    end
  end

  // Y86 power-up condition codes: ZF set, SF/OF clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;

  // Evaluation always sees the registered flags; there is no bypass from alu_out.
  always_comb begin
    cnd = 1'b0;
    case (cond_fn)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf_q ^ of_q) | zf_q;
      4'd2:    cnd = sf_q ^ of_q;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~(sf_q ^ of_q);
      4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  assign cond_err = eval_valid & (cond_fn > 4'd6);

`ifdef CC_STATS_EN
  logic [STAT_W-1:0] taken_q, taken_d;
  logic [STAT_W-1:0] ntaken_q, ntaken_d;

  // Saturating counters; stall does not gate counting.
  always_comb begin
    taken_d  = taken_q;
    ntaken_d = ntaken_q;
    if (eval_valid && !cond_err) begin
      if (cnd) begin
        if (taken_q != '1) taken_d = taken_q + STAT_W'(1);
      end else begin
        if (ntaken_q != '1) ntaken_d = ntaken_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q  <= '0;
      ntaken_q <= '0;
    end else begin
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
    end
  end

  assign taken_cnt  = taken_q;
  assign ntaken_cnt = ntaken_q;
`endif

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit with hand-computed expected flag and condition values.
module tb_cc_unit;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned STAT_W = 32;

  logic             clk;
  logic             rst;
  logic             set_cc;
  logic             cc_stall;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;
  logic             eval_valid;
  logic [3:0]       cond_fn;
  logic             zf, sf, of, cnd, cond_err, cc_live;
`ifdef CC_STATS_EN
  logic [STAT_W-1:0] taken_cnt, ntaken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cc_unit #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_cc     (set_cc),
    .cc_stall   (cc_stall),
    .alu_out    (alu_out),
    .alu_ovf    (alu_ovf),
    .eval_valid (eval_valid),
    .cond_fn    (cond_fn),
    .zf         (zf),
    .sf         (sf),
    .of         (of),
    .cnd        (cnd),
    .cond_err   (cond_err),
    .cc_live    (cc_live)
`ifdef CC_STATS_EN
    ,
    .taken_cnt  (taken_cnt),
    .ntaken_cnt (ntaken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic s, input logic o);
    check({tag, ".zf"}, 64'(zf), 64'(z));
    check({tag, ".sf"}, 64'(sf), 64'(s));
    check({tag, ".of"}, 64'(of), 64'(o));
  endtask

  task automatic check_cnd(input string tag, input logic [3:0] fn, input logic exp);
    cond_fn = fn;
    #1;
    check(tag, 64'(cnd), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; set_cc = 1'b0; cc_stall = 1'b0; alu_out = '0; alu_ovf = 1'b0;
    eval_valid = 1'b0; cond_fn = 4'd0;
    step(); step();

    // 1. reset state
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    check("rst.live", 64'(cc_live), 64'd0);
    check_cnd("rst.cnd_e", 4'd3, 1'b1);
    check_cnd("rst.cnd_ne", 4'd4, 1'b0);
    check_cnd("rst.cnd_always", 4'd0, 1'b1);
    rst = 1'b0;
    step();
    check("idle.live", 64'(cc_live), 64'd0);

    // 2. capture of a negative result
    set_cc = 1'b1; alu_out = 64'hFFFF_FFFF_FFFF_FFFB; alu_ovf = 1'b0;
    step();
    set_cc = 1'b0;
    check_flags("cap", 1'b0, 1'b1, 1'b0);
    check("cap.live", 64'(cc_live), 64'd1);
    check_cnd("cap.cnd_l", 4'd2, 1'b1);
    check_cnd("cap.cnd_le", 4'd1, 1'b1);
    check_cnd("cap.cnd_g", 4'd6, 1'b0);
    check_cnd("cap.cnd_ge", 4'd5, 1'b0);

    // 3. overflow: sf^of = 0
    set_cc = 1'b1; alu_out = 64'h8000_0000_0000_0000; alu_ovf = 1'b1;
    step();
    set_cc = 1'b0;
    check_flags("ovf", 1'b0, 1'b1, 1'b1);
    check_cnd("ovf.cnd_l", 4'd2, 1'b0);
    check_cnd("ovf.cnd_ge", 4'd5, 1'b1);
    check_cnd("ovf.cnd_le", 4'd1, 1'b0);
    check_cnd("ovf.cnd_g", 4'd6, 1'b1);

    // 4. stall overrides set_cc
    set_cc = 1'b1; cc_stall = 1'b1; alu_out = '0; alu_ovf = 1'b0;
    step();
    check_flags("stall", 1'b0, 1'b1, 1'b1);
    cc_stall = 1'b0;
    step();
    set_cc = 1'b0;
    check_flags("unstall", 1'b1, 1'b0, 1'b0);
    check_cnd("unstall.cnd_le", 4'd1, 1'b1);

    // 5. same-cycle evaluation uses old flags
    set_cc = 1'b1; alu_out = 64'd7; eval_valid = 1'b1;
    check_cnd("same.cnd_pre", 4'd3, 1'b1);
    check("same.err", 64'(cond_err), 64'd0);
    step();
    set_cc = 1'b0; eval_valid = 1'b0;
    check_flags("same.post", 1'b0, 1'b0, 1'b0);
    check_cnd("same.cnd_post", 4'd3, 1'b0);
    check_cnd("same.cnd_g", 4'd6, 1'b1);

    // 6. bad function codes
    eval_valid = 1'b1;
    check_cnd("bad9.cnd", 4'd9, 1'b0);
    check("bad9.err", 64'(cond_err), 64'd1);
    check_cnd("bad7.cnd", 4'd7, 1'b0);
    check("bad7.err", 64'(cond_err), 64'd1);
    check_cnd("fn6.cnd", 4'd6, 1'b1);
    check("fn6.err", 64'(cond_err), 64'd0);
    eval_valid = 1'b0;
    cond_fn = 4'd15;
    #1;
    check("bad15.noeval.err", 64'(cond_err), 64'd0);
    step();
    check_flags("bad.flags", 1'b0, 1'b0, 1'b0);

    // 7. async reset mid-cycle drops an in-flight capture
    set_cc = 1'b1; alu_out = 64'h8000_0000_0000_0001; alu_ovf = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_flags("async", 1'b1, 1'b0, 1'b0);
    check("async.live", 64'(cc_live), 64'd0);
    step();
    check_flags("async.edge", 1'b1, 1'b0, 1'b0);
    set_cc = 1'b0;
    rst = 1'b0;
    step();
    check("async.hold.live", 64'(cc_live), 64'd0);
    check_flags("async.hold", 1'b1, 1'b0, 1'b0);

`ifdef CC_STATS_EN
    // 8. counters: bad fn ignored, 3 taken, 1 not-taken
    eval_valid = 1'b1; cond_fn = 4'd9;
    step();
    check("stat.bad.taken", 64'(taken_cnt), 64'd0);
    check("stat.bad.ntaken", 64'(ntaken_cnt), 64'd0);
    cond_fn = 4'd3;
    step(); step(); step();
    check("stat.taken", 64'(taken_cnt), 64'd3);
    cond_fn = 4'd4;
    step();
    eval_valid = 1'b0;
    check("stat.ntaken", 64'(ntaken_cnt), 64'd1);
    check("stat.taken.hold", 64'(taken_cnt), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
